sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
- Single-clock, parametrised FIFO; next generation of the team's FIFO family for same-clock producer/consumer paths.
- Adds over the previous generation:
  - arbitrary (non-power-of-two) depth
  - registered fill level
  - programmable almost-full / almost-empty flags
  - selectable standard or first-word-fall-through (FWFT) read mode
- Sits between a datapath producer and consumer in one clock domain; keeps the family's wr/rd/datain/dataout/full/empty signal set.

Parameters:
- WIDTH, 18: data word width in bits, >= 1.
- DEPTH, 16: number of storage entries, >= 2, any integer.
- AF_LEVEL, 12: almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard read mode, 1 = first-word-fall-through read mode.

Ports:
- clk  input  1  single clock for all logic; rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- wr  input  1  write request; data is accepted when wr=1 and the write is accepted per Behaviour (not full, or full with a simultaneous accepted read).
- datain  input  WIDTH  write data, sampled on an accepted write.
- rd  input  1  read request; data is popped when rd=1 and empty=0.
- dataout  output  WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  $clog2(DEPTH+1)  current fill level.

Behaviour:
- Reset (reset_n=0, asynchronous assert, release synchronous to clk):
  - count=0, empty=1, full=0, almost_empty=1, almost_full=0, dataout=0.
  - Both pointers cleared to 0.
  - Memory contents are not reset.
- Reset mid-operation: all stored data is discarded; flags return to reset values immediately, without waiting for a clk edge.
- Pointers: wr_ptr and rd_ptr each span 0..DEPTH-1 and wrap from DEPTH-1 to 0 by explicit compare, not power-of-two masking.
- count update:
  - accepted write and no accepted read: count+1
  - accepted read and no accepted write: count-1
  - both or neither: count unchanged
- All flags and count are registered. They reflect a transaction on the clk edge after it (1-cycle latency).
- Write when full with rd=0: ignored. Memory, pointers and count unchanged.
- Read when empty: ignored. Pointers unchanged; dataout holds its value.
- Simultaneous rd and wr when full: both accepted; count stays DEPTH; full stays 1.
- Simultaneous rd and wr when empty:
  - write accepted, read ignored; count becomes 1.
  - This holds in both modes; no bypass of an empty FIFO.
- Standard mode (FWFT=0):
  - dataout is registered; the popped word appears on the clk edge after the read (1-cycle read latency).
  - dataout holds between reads.
- FWFT mode (FWFT=1):
  - dataout continuously shows the word at rd_ptr whenever empty=0.
  - rd acknowledges/pops that word; the next word is visible the cycle after the pop edge.
  - When empty=1, dataout holds its last value.
  - First write into an empty FIFO: empty deasserts and the word is visible on dataout 1 cycle after the write edge.
- Flag boundaries:
  - full rises on the edge where count goes DEPTH-1 -> DEPTH.
  - empty rises on the edge where count goes 1 -> 0.
  - almost_* flags track count comparisons exactly as defined, including when AF_LEVEL=DEPTH (almost_full identical to full).

Optional Feature:
- Macro: SYNC_FIFO_ERR_FLAGS_EN.
- When defined, two extra outputs exist:
  - overflow (1 bit): sticky; set on the edge after wr=1 while full=1 and rd=0.
  - underflow (1 bit): sticky; set on the edge after rd=1 while empty=1.
  - Both cleared only by reset_n=0; reset value 0. Dropped transactions still have no other effect.
- When not defined: the ports and associated logic are absent; all other behaviour is identical.

Test Plan:
- Reset then fill: reset_n=0 for 3 clks; release; wr=1 with datain=1..16 (DEPTH=16).
  -> count steps 1..16; almost_full rises on the edge where count reaches 12; full=1 after the 16th write.
  -> 17th write (value 17) ignored; overflow=1 if enabled.
- Drain, standard mode: from full, rd=1 for 16 cycles.
  -> dataout = 1..16 in order, each one cycle after its rd edge.
  -> almost_empty rises at count=2; empty=1 after the last pop; a further rd leaves dataout=16; underflow=1 if enabled.
- FWFT: FWFT=1; single write of 0x2A5 into empty FIFO.
  -> next cycle empty=0 and dataout=0x2A5 with rd=0; rd=1 for one cycle -> empty=1, count=0.
- Simultaneous full: fill to 16; assert rd=1 and wr=1 with datain=0x3FFFF for one cycle.
  -> count stays 16, full stays 1; the value 0x3FFFF is read out last.
- Non-power-of-two wrap: DEPTH=5; write 3, read 3, then write 5 values 10..14.
  -> full=1 with count=5; reading returns 10..14 in order across the pointer wrap.
- Async reset mid-stream: with count=7, pulse reset_n low between clk edges.
  -> empty=1, count=0, full=0 immediately; after release, a new write/read of 0x155 returns 0x155.

Source files
------------

// File: rtl/sync_fifo_param.sv
`timescale 1ns/1ps
// Single-clock FIFO: arbitrary depth, registered count and flags, standard or FWFT read.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo_param #(
    parameter int unsigned WIDTH    = 18,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           datain,
    input  logic                       rd,
    output logic [WIDTH-1:0]           dataout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                       overflow,
    output logic                       underflow
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] dataout_nxt;
    logic             wr_ok, rd_ok;

    // Acceptance, pointer wrap by compare, next fill level and next output word.
    always_comb begin
        rd_ok       = rd && !empty;
        wr_ok       = wr && (!full || rd_ok);
        wr_ptr_nxt  = wr_ptr;
        rd_ptr_nxt  = rd_ptr;
        count_nxt   = count;
        dataout_nxt = dataout;

        if (wr_ok) begin
            wr_ptr_nxt = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
        end
        if (rd_ok) begin
            rd_ptr_nxt = (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
        end

        if (wr_ok && !rd_ok) begin
            count_nxt = count + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - CW'(1);
        end

        // FWFT preloads the next head; a word written this edge may itself be the head.
        if (FWFT != 0) begin
            if (count_nxt != '0) begin
                dataout_nxt = (wr_ok && (rd_ptr_nxt == wr_ptr)) ? datain : mem[rd_ptr_nxt];
            end
        end else if (rd_ok) begin
            dataout_nxt = mem[rd_ptr];
        end
    end

    // Storage array; contents intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= datain;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            dataout      <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            count        <= count_nxt;
            dataout      <= dataout_nxt;
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CW'(AF_LEVEL));
            almost_empty <= (count_nxt <= CW'(AE_LEVEL));
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // Sticky error flags for dropped requests.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr && full && !rd) begin
                overflow <= 1'b1;
            end
            if (rd && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
`timescale 1ns/1ps
// Directed bench for sync_fifo_param: default, FWFT and depth-5 instances.
module tb_sync_fifo_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // Instance A: defaults (DEPTH 16, standard mode)
    logic        a_wr, a_rd, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [17:0] a_din, a_dout;
    logic [4:0]  a_cnt;
    // Instance B: FWFT
    logic        b_wr, b_rd, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [17:0] b_din, b_dout;
    logic [4:0]  b_cnt;
    // Instance C: DEPTH 5
    logic        c_wr, c_rd, c_full, c_empty, c_af, c_ae, c_ovf, c_unf;
    logic [17:0] c_din, c_dout;
    logic [2:0]  c_cnt;

    sync_fifo_param dut_a (
        .clk(clk), .reset_n(reset_n), .wr(a_wr), .datain(a_din), .rd(a_rd),
        .dataout(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
        .almost_empty(a_ae), .count(a_cnt)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .overflow(a_ovf), .underflow(a_unf)
`endif
    );

    sync_fifo_param #(.FWFT(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .wr(b_wr), .datain(b_din), .rd(b_rd),
        .dataout(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
        .almost_empty(b_ae), .count(b_cnt)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .overflow(b_ovf), .underflow(b_unf)
`endif
    );

    sync_fifo_param #(.DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .wr(c_wr), .datain(c_din), .rd(c_rd),
        .dataout(c_dout), .full(c_full), .empty(c_empty), .almost_full(c_af),
        .almost_empty(c_ae), .count(c_cnt)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        , .overflow(c_ovf), .underflow(c_unf)
`endif
    );

    typedef struct {
        logic        wr;
        logic        rd;
        logic [17:0] din;
        logic [4:0]  cnt;
        logic        full;
        logic        empty;
        logic        af;
        logic        ae;
        logic [17:0] dout;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic r, input logic [17:0] d,
                                input logic [4:0] c, input logic f, input logic e,
                                input logic af, input logic ae, input logic [17:0] q);
        vec_t v;
        v.wr = w; v.rd = r; v.din = d; v.cnt = c;
        v.full = f; v.empty = e; v.af = af; v.ae = ae; v.dout = q;
        return v;
    endfunction

    task automatic a_step(input logic w, input logic r, input logic [17:0] d);
        a_wr = w; a_rd = r; a_din = d;
        @(posedge clk); #1;
        a_wr = 1'b0; a_rd = 1'b0;
    endtask

    task automatic b_step(input logic w, input logic r, input logic [17:0] d);
        b_wr = w; b_rd = r; b_din = d;
        @(posedge clk); #1;
        b_wr = 1'b0; b_rd = 1'b0;
    endtask

    task automatic c_step(input logic w, input logic r, input logic [17:0] d);
        c_wr = w; c_rd = r; c_din = d;
        @(posedge clk); #1;
        c_wr = 1'b0; c_rd = 1'b0;
    endtask

    vec_t tab[$];

    initial begin
        reset_n = 1'b0;
        a_wr = 0; a_rd = 0; a_din = '0;
        b_wr = 0; b_rd = 0; b_din = '0;
        c_wr = 0; c_rd = 0; c_din = '0;
        a_ovf = 0; a_unf = 0; b_ovf = 0; b_unf = 0; c_ovf = 0; c_unf = 0;

        // Fill 1..16, then an ignored 17th write
        for (int i = 1; i <= 16; i++)
            tab.push_back(mk(1'b1, 1'b0, 18'(i), 5'(i), i == 16, 1'b0, i >= 12, i <= 2, 18'd0));
        tab.push_back(mk(1'b1, 1'b0, 18'd17, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 18'd0));
        // Drain 16, then an ignored read on empty
        for (int j = 1; j <= 16; j++)
            tab.push_back(mk(1'b0, 1'b1, 18'd0, 5'(16 - j), 1'b0, j == 16,
                             (16 - j) >= 12, (16 - j) <= 2, 18'(j)));
        tab.push_back(mk(1'b0, 1'b1, 18'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 18'd16));
        // Refill with 0x100.., simultaneous rd/wr while full, drain
        for (int i = 0; i < 16; i++)
            tab.push_back(mk(1'b1, 1'b0, 18'h100 + 18'(i), 5'(i + 1), i == 15, 1'b0,
                             (i + 1) >= 12, (i + 1) <= 2, 18'd16));
        tab.push_back(mk(1'b1, 1'b1, 18'h3FFFF, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 18'h100));
        for (int j = 1; j <= 16; j++)
            tab.push_back(mk(1'b0, 1'b1, 18'd0, 5'(16 - j), 1'b0, j == 16,
                             (16 - j) >= 12, (16 - j) <= 2,
                             (j < 16) ? 18'h100 + 18'(j) : 18'h3FFFF));

        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 32'(a_cnt), 32'd0);
        chk("rst_empty", 32'(a_empty), 32'd1);
        chk("rst_full", 32'(a_full), 32'd0);
        chk("rst_ae", 32'(a_ae), 32'd1);
        chk("rst_af", 32'(a_af), 32'd0);
        chk("rst_dout", 32'(a_dout), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("rst_ovf", 32'(a_ovf), 32'd0);
        chk("rst_unf", 32'(a_unf), 32'd0);
`endif
        reset_n = 1'b1;

        for (int k = 0; k < tab.size(); k++) begin
            a_step(tab[k].wr, tab[k].rd, tab[k].din);
            chk($sformatf("v%0d_count", k), 32'(a_cnt), 32'(tab[k].cnt));
            chk($sformatf("v%0d_full", k), 32'(a_full), 32'(tab[k].full));
            chk($sformatf("v%0d_empty", k), 32'(a_empty), 32'(tab[k].empty));
            chk($sformatf("v%0d_af", k), 32'(a_af), 32'(tab[k].af));
            chk($sformatf("v%0d_ae", k), 32'(a_ae), 32'(tab[k].ae));
            chk($sformatf("v%0d_dout", k), 32'(a_dout), 32'(tab[k].dout));
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("ovf_sticky", 32'(a_ovf), 32'd1);
        chk("unf_sticky", 32'(a_unf), 32'd1);
`endif

        // Asynchronous reset with 7 words stored
        for (int i = 0; i < 7; i++) a_step(1'b1, 1'b0, 18'h20 + 18'(i));
        chk("pre_rst_count", 32'(a_cnt), 32'd7);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("arst_empty", 32'(a_empty), 32'd1);
        chk("arst_count", 32'(a_cnt), 32'd0);
        chk("arst_full", 32'(a_full), 32'd0);
        chk("arst_ae", 32'(a_ae), 32'd1);
        chk("arst_dout", 32'(a_dout), 32'd0);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("arst_ovf", 32'(a_ovf), 32'd0);
`endif
        #1;
        reset_n = 1'b1;
        a_step(1'b1, 1'b0, 18'h155);
        chk("post_rst_count", 32'(a_cnt), 32'd1);
        a_step(1'b0, 1'b1, 18'd0);
        chk("post_rst_dout", 32'(a_dout), 32'h155);
        chk("post_rst_empty", 32'(a_empty), 32'd1);

        // FWFT instance
        b_step(1'b1, 1'b0, 18'h2A5);
        chk("fwft_empty", 32'(b_empty), 32'd0);
        chk("fwft_dout", 32'(b_dout), 32'h2A5);
        chk("fwft_count", 32'(b_cnt), 32'd1);
        b_step(1'b0, 1'b0, 18'd0);
        chk("fwft_idle_dout", 32'(b_dout), 32'h2A5);
        b_step(1'b0, 1'b1, 18'd0);
        chk("fwft_pop_empty", 32'(b_empty), 32'd1);
        chk("fwft_pop_count", 32'(b_cnt), 32'd0);
        chk("fwft_hold_dout", 32'(b_dout), 32'h2A5);
        b_step(1'b1, 1'b0, 18'h11);
        chk("fwft_w1_dout", 32'(b_dout), 32'h11);
        b_step(1'b1, 1'b0, 18'h22);
        chk("fwft_w2_dout", 32'(b_dout), 32'h11);
        chk("fwft_w2_count", 32'(b_cnt), 32'd2);
        b_step(1'b0, 1'b1, 18'd0);
        chk("fwft_next_dout", 32'(b_dout), 32'h22);
        b_step(1'b1, 1'b1, 18'h33);
        chk("fwft_rw1_dout", 32'(b_dout), 32'h33);
        chk("fwft_rw1_count", 32'(b_cnt), 32'd1);
        b_step(1'b0, 1'b1, 18'd0);
        chk("fwft_last_empty", 32'(b_empty), 32'd1);
        chk("fwft_last_dout", 32'(b_dout), 32'h33);
        b_step(1'b1, 1'b1, 18'h44);
        chk("fwft_rw0_count", 32'(b_cnt), 32'd1);
        chk("fwft_rw0_empty", 32'(b_empty), 32'd0);
        chk("fwft_rw0_dout", 32'(b_dout), 32'h44);

        // Depth-5 pointer wrap
        for (int i = 1; i <= 3; i++) c_step(1'b1, 1'b0, 18'(i));
        chk("d5_count3", 32'(c_cnt), 32'd3);
        for (int i = 1; i <= 3; i++) begin
            c_step(1'b0, 1'b1, 18'd0);
            chk($sformatf("d5_rd%0d", i), 32'(c_dout), 32'(i));
        end
        chk("d5_empty", 32'(c_empty), 32'd1);
        for (int i = 0; i < 5; i++) begin
            c_step(1'b1, 1'b0, 18'd10 + 18'(i));
            chk($sformatf("d5_wcnt%0d", i), 32'(c_cnt), 32'(i + 1));
            chk($sformatf("d5_af%0d", i), 32'(c_af), 32'(i >= 3));
            chk($sformatf("d5_ae%0d", i), 32'(c_ae), 32'(i == 0));
        end
        chk("d5_full", 32'(c_full), 32'd1);
        c_step(1'b1, 1'b0, 18'd99);
        chk("d5_ovr_count", 32'(c_cnt), 32'd5);
        for (int i = 0; i < 5; i++) begin
            c_step(1'b0, 1'b1, 18'd0);
            chk($sformatf("d5_wrap_rd%0d", i), 32'(c_dout), 32'd10 + 32'(i));
        end
        chk("d5_final_empty", 32'(c_empty), 32'd1);
        chk("d5_final_full", 32'(c_full), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
